packet_match_ctrl: RTL and testbench
====================================

# packet_match_ctrl

Parametrised packet-match controller for the sniffer datapath. It sequences packet intake from the MAC input FIFO and waits out the comparator pipeline. It then forms a weighted match score over `NUM_CH` comparator flags against a run-time threshold, keeps a saturating hit counter per channel, and pulses the capture-buffer address increment for packets that qualify. It sits between the MAC/input FIFO, the comparator bank, the Avalon configuration slave and the capture memory.

## Interface
Parameters:
- `NUM_CH`, 4: number of comparator channels (port, ip, mac, url, ...).
- `CNT_W`, 32: width of each hit counter.
- `WEIGHT_W`, 3: width of each per-channel weight.
- `COMP_LAT`, 4: comparator pipeline latency in cycles between `eop` and valid match flags (>=1).
- `EMPTY_W`, 2: width of FIFO `empty`.
- `EMPTY_LIM`, 3: `ready` is allowed in IDLE only while `empty < EMPTY_LIM`.

Ports:
- `clk` in 1: clock.
- `n_rst` in 1: reset. Synchronous and active-low. It takes effect only on the rising edge of `clk`.
- `update_done` in 1: configuration load from the Avalon slave is complete.
- `weights` in `NUM_CH*WEIGHT_W`: per-channel weights. Channel i occupies `[i*WEIGHT_W +: WEIGHT_W]`.
- `threshold` in `WEIGHT_W+$clog2(NUM_CH)+1`: score needed for a qualifying packet.
- `sop`, `eop`, `valid` in 1 each: MAC Avalon-ST framing.
- `error` in 6: MAC error field. Any nonzero value means an errored packet.
- `empty` in `EMPTY_W`: input FIFO empty count.
- `match` in `NUM_CH`: comparator match flags, sticky until `clear`.
- `ready` out 1: ready to the input FIFO.
- `clear` out 1: clears the comparator flags.
- `inc_addr` out 1: one-cycle increment for the capture address.
- `hits` out `NUM_CH*CNT_W`: per-channel hit counters.
- `pkt_cnt` out `CNT_W`: count of completed, non-errored packets.
- `err_cnt` out `CNT_W`: count of errored packets (see Configuration).

## Operation
- States: LOAD_CFG, IDLE, COMPARE, DRAIN, SCORE, STORE, ERROR. Reset enters LOAD_CFG.
- LOAD_CFG -> IDLE on `update_done`.
  - `weights` and `threshold` are latched into internal registers on that cycle.
  - Registers are not re-latched until the next LOAD_CFG.
- IDLE -> COMPARE when `sop & valid`.
- COMPARE transitions:
  - to DRAIN on `eop`;
  - otherwise to ERROR when `error != 0`;
  - `eop` has priority when both occur in the same cycle.
- DRAIN holds for exactly `COMP_LAT` cycles, using a down-counter of width `$clog2(COMP_LAT+1)`, then goes to SCORE.
- In SCORE:
  - score = sum over i of (`match[i]` ? `weight[i]` : 0), computed at full width so it cannot overflow;
  - score >= threshold -> STORE, else -> IDLE;
  - each `hits[i]` with `match[i]`=1 increments by 1;
  - `pkt_cnt` increments by 1.
- STORE -> IDLE unconditionally.
- ERROR -> IDLE on `eop`.
- All counters saturate at all-ones and never wrap.
- Outputs are registered and decoded from the next state:
  - LOAD_CFG: ready=0, clear=0, inc_addr=0.
  - IDLE: clear=1, inc_addr=0, ready=(`empty < EMPTY_LIM`).
  - COMPARE and ERROR: ready=1, clear=0.
  - DRAIN: ready=0, clear=0.
  - SCORE: ready=0, clear=1.
  - STORE: inc_addr=1, ready=0, clear=0.
- Reset value of every output is 0: `ready`, `clear`, `inc_addr`, `hits`, `pkt_cnt`, `err_cnt`. Latched weights and threshold also reset to 0.
- Reset asserted mid-packet:
  - all state is discarded at the next edge;
  - the partial packet is not counted;
  - the block returns to LOAD_CFG and needs a fresh `update_done`.

## Timing
- `sop & valid` sampled in IDLE at edge k -> state COMPARE and `ready`=1 from edge k.
- `eop` sampled at edge e -> DRAIN during cycles e..e+COMP_LAT-1 -> SCORE at e+COMP_LAT.
  - `hits`/`pkt_cnt` update visible at e+COMP_LAT+1.
  - `inc_addr` high for exactly the single cycle e+COMP_LAT+1 when the packet qualifies.
- `match` is sampled only in the SCORE cycle.
- `sop` outside IDLE is ignored. A back-to-back packet waits until IDLE is re-entered.
- `weights` changes outside LOAD_CFG have no effect.

## Configuration
- `PKT_MATCH_ERRCNT_EN` defined:
  - `err_cnt` increments once per entry into ERROR;
  - it saturates at all-ones.
- Not defined: `err_cnt` is tied to constant 0 and the counter logic is not built. ERROR-state sequencing is unchanged.

## Structure
- Shared package `sniffer_pkg` holds:
  - the state enum `match_state_t`;
  - the error-field width constant (6);
  - a function for the score width, `WEIGHT_W+$clog2(NUM_CH)+1`.
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `n_rst`, `inc`, `q`), instantiated `NUM_CH+2` times.

## Test plan
- Setup: `NUM_CH`=4, `weights`={4,2,2,1} (url,mac,ip,port), `threshold`=4, `update_done` pulse.
  - Packet with match=4'b0011 -> score 3.
  - Required: no `inc_addr`; `hits[0]`=1, `hits[1]`=1, `pkt_cnt`=1.
- Same config, match=4'b1000 -> score 4.
  - Required: `inc_addr`=1 for one cycle exactly `COMP_LAT`+1 cycles after `eop`; `hits[3]`=1.
- `error`=6'h01 mid-packet, then `eop` two cycles later.
  - Required: state ERROR, `ready`=1, then IDLE.
  - `pkt_cnt` unchanged.
  - `err_cnt`=1 with the macro defined, 0 without.
- `CNT_W`=4, 17 packets with `match[0]`=1.
  - Required: `hits[0]`=15 after packets 15, 16 and 17 (saturation, no wrap).
- `n_rst` low for one edge during DRAIN.
  - Required: all outputs 0 next cycle.
  - State LOAD_CFG; `ready` stays 0 until `update_done`.
- In IDLE with `empty`=3 (`EMPTY_LIM`=3): `ready`=0. With `empty`=2: `ready`=1 on the following cycle.

Source files
------------

// File: rtl/sniffer_pkg.sv
// Shared sniffer types: match-controller state encoding, MAC error width, score width helper.
package sniffer_pkg;

  localparam int ERR_W = 6;

  typedef enum logic [2:0] {
    LOAD_CFG,
    IDLE,
    COMPARE,
    DRAIN,
    SCORE,
    STORE,
    ERROR
  } match_state_t;

  // Wide enough that NUM_CH maximal weights can never overflow the sum.
  function automatic int score_width(input int weight_w, input int num_ch);
    return weight_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/packet_match_ctrl_if.sv
// MAC Avalon-ST framing plus input-FIFO level toward the match controller, ready back to the FIFO.
interface packet_match_ctrl_if #(
  parameter int EMPTY_W = 2
) ();
  import sniffer_pkg::*;

  logic               sop;
  logic               eop;
  logic               valid;
  logic [ERR_W-1:0]   error;
  logic [EMPTY_W-1:0] empty;
  logic               ready;

  modport master (output sop, eop, valid, error, empty, input ready);
  modport slave  (input sop, eop, valid, error, empty, output ready);
endinterface

// File: rtl/sat_counter.sv
// Synchronous-reset up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;
endmodule

// File: rtl/packet_match_ctrl.sv
// Packet-match sequencer: intake, comparator drain, weighted score vs threshold, hit counters, capture pulse.
// Outputs registered from next state; define PKT_MATCH_ERRCNT_EN to build the errored-packet counter.
module packet_match_ctrl
  import sniffer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int WEIGHT_W  = 3,
  parameter int COMP_LAT  = 4,
  parameter int EMPTY_W   = 2,
  parameter int EMPTY_LIM = 3
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     update_done,
  input  logic [NUM_CH*WEIGHT_W-1:0]               weights,
  input  logic [score_width(WEIGHT_W, NUM_CH)-1:0] threshold,
  packet_match_ctrl_if.slave                       mac,
  input  logic [NUM_CH-1:0]                        match,
  output logic                                     clear,
  output logic                                     inc_addr,
  output logic [NUM_CH*CNT_W-1:0]                  hits,
  output logic [CNT_W-1:0]                         pkt_cnt,
  output logic [CNT_W-1:0]                         err_cnt
);
  localparam int SCORE_W = score_width(WEIGHT_W, NUM_CH);
  localparam int DRN_W   = $clog2(COMP_LAT + 1);
  localparam int LIM_W   = EMPTY_W + 1;
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(COMP_LAT - 1);
  localparam logic [LIM_W-1:0] EMPTY_MAX  = LIM_W'(EMPTY_LIM);

  match_state_t               r_state;
  match_state_t               w_next;
  logic [DRN_W-1:0]           r_drain;
  logic [NUM_CH*WEIGHT_W-1:0] r_weights;
  logic [SCORE_W-1:0]         r_threshold;
  logic [SCORE_W-1:0]         w_score;
  logic                       r_ready, r_clear, r_inc;
  logic                       w_ready, w_clear, w_inc;
  logic                       w_room;
  logic                       w_in_score;
  logic [NUM_CH-1:0]          w_hit_inc;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= LOAD_CFG;
    end else begin
      r_state <= w_next;
    end
  end

  // Configuration is captured once per LOAD_CFG visit; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_weights   <= '0;
      r_threshold <= '0;
    end else if ((r_state == LOAD_CFG) && update_done) begin
      r_weights   <= weights;
      r_threshold <= threshold;
    end
  end

  // Preloaded while outside DRAIN so the first DRAIN cycle already holds COMP_LAT-1.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_drain <= '0;
    end else if (r_state != DRAIN) begin
      r_drain <= DRAIN_INIT;
    end else if (r_drain != '0) begin
      r_drain <= r_drain - DRN_W'(1);
    end
  end

  always_comb begin
    w_score = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (match[i]) begin
        w_score = w_score + SCORE_W'(r_weights[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_CFG: if (update_done) w_next = IDLE;
      IDLE:     if (mac.sop && mac.valid) w_next = COMPARE;
      COMPARE: begin
        if (mac.eop) begin
          w_next = DRAIN;
        end else if (mac.error != '0) begin
          w_next = ERROR;
        end
      end
      DRAIN:    if (r_drain == '0) w_next = SCORE;
      SCORE:    w_next = (w_score >= r_threshold) ? STORE : IDLE;
      STORE:    w_next = IDLE;
      ERROR:    if (mac.eop) w_next = IDLE;
      default:  w_next = LOAD_CFG;
    endcase
  end

  assign w_room = ({1'b0, mac.empty} < EMPTY_MAX);

  always_comb begin
    w_ready = 1'b0;
    w_clear = 1'b0;
    w_inc   = 1'b0;
    case (w_next)
      IDLE: begin
        w_clear = 1'b1;
        w_ready = w_room;
      end
      COMPARE, ERROR: w_ready = 1'b1;
      SCORE:          w_clear = 1'b1;
      STORE:          w_inc   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ready <= 1'b0;
      r_clear <= 1'b0;
      r_inc   <= 1'b0;
    end else begin
      r_ready <= w_ready;
      r_clear <= w_clear;
      r_inc   <= w_inc;
    end
  end

  assign mac.ready = r_ready;
  assign clear     = r_clear;
  assign inc_addr  = r_inc;

  assign w_in_score = (r_state == SCORE);
  assign w_hit_inc  = match & {NUM_CH{w_in_score}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hits
    sat_counter #(.W(CNT_W)) u_hit (
      .clk   (clk),
      .n_rst (n_rst),
      .inc   (w_hit_inc[i]),
      .q     (hits[i*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_pkt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (w_in_score),
    .q     (pkt_cnt)
  );

`ifdef PKT_MATCH_ERRCNT_EN
  logic w_err_inc;
  assign w_err_inc = (r_state == COMPARE) && (w_next == ERROR);

  sat_counter #(.W(CNT_W)) u_err (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (w_err_inc),
    .q     (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_packet_match_ctrl.sv
// Randomized and directed bench for packet_match_ctrl against a transaction-level reference model.
module tb_packet_match_ctrl;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 4;
  localparam int COMP_LAT = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int P_LOAD = 0, P_IDLE = 1, P_CMP = 2, P_DRAIN = 3, P_SCORE = 4, P_STORE = 5, P_ERR = 6;
`ifdef PKT_MATCH_ERRCNT_EN
  localparam int ERR_ONE = 1;
`else
  localparam int ERR_ONE = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        update_done = 1'b0;
  logic [11:0] weights = '0;
  logic [5:0]  threshold = '0;
  logic [3:0]  match = '0;
  logic        clear, inc_addr;
  logic [15:0] hits;
  logic [3:0]  pkt_cnt, err_cnt;

  packet_match_ctrl_if #(.EMPTY_W(2)) mac ();

  packet_match_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WEIGHT_W(3),
    .COMP_LAT(COMP_LAT), .EMPTY_W(2), .EMPTY_LIM(3)
  ) dut (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .weights(weights),
    .threshold(threshold), .mac(mac), .match(match), .clear(clear),
    .inc_addr(inc_addr), .hits(hits), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, eop_cyc = 0, inc_cyc = 0, inc_cnt = 0;
  bit  chk_en = 0, rnd_empty = 0, rnd_match = 0;

  // Reference model: packet-level bookkeeping in plain integers
  int  m_ph = P_LOAD, m_wait = 0, m_thr = 0, m_pkt = 0, m_err = 0;
  int  m_w[NUM_CH];
  int  m_hits[NUM_CH];
  bit  exp_ready = 0, exp_clear = 0, exp_inc = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk) begin : model
    int sc;
    cyc++;
    if (!n_rst) begin
      m_ph = P_LOAD; m_wait = 0; m_thr = 0; m_pkt = 0; m_err = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_w[i] = 0; m_hits[i] = 0; end
    end else begin
      case (m_ph)
        P_LOAD: if (update_done) begin
          for (int i = 0; i < NUM_CH; i++) m_w[i] = int'(weights[i*3 +: 3]);
          m_thr = int'(threshold);
          m_ph = P_IDLE;
        end
        P_IDLE: if (mac.sop && mac.valid) m_ph = P_CMP;
        P_CMP: if (mac.eop) begin
          m_ph = P_DRAIN; m_wait = COMP_LAT;
        end else if (mac.error != 0) begin
          m_ph = P_ERR; m_err = sat(m_err + ERR_ONE);
        end
        P_DRAIN: begin
          m_wait--;
          if (m_wait == 0) m_ph = P_SCORE;
        end
        P_SCORE: begin
          sc = 0;
          for (int i = 0; i < NUM_CH; i++) if (match[i]) begin
            sc += m_w[i];
            m_hits[i] = sat(m_hits[i] + 1);
          end
          m_pkt = sat(m_pkt + 1);
          m_ph = (sc >= m_thr) ? P_STORE : P_IDLE;
        end
        P_STORE: m_ph = P_IDLE;
        default: if (mac.eop) m_ph = P_IDLE;
      endcase
    end
    exp_ready = (m_ph == P_IDLE && mac.empty < 3) || m_ph == P_CMP || m_ph == P_ERR;
    exp_clear = (m_ph == P_IDLE) || (m_ph == P_SCORE);
    exp_inc   = (m_ph == P_STORE);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin : compare
    #1;
    if (inc_addr === 1'b1) begin inc_cnt++; inc_cyc = cyc; end
    if (chk_en) begin
      check("ready", {31'd0, mac.ready}, {31'd0, exp_ready});
      check("clear", {31'd0, clear}, {31'd0, exp_clear});
      check("inc_addr", {31'd0, inc_addr}, {31'd0, exp_inc});
      for (int i = 0; i < NUM_CH; i++) check("hits", 32'(hits[i*CNT_W +: CNT_W]), m_hits[i]);
      check("pkt_cnt", 32'(pkt_cnt), m_pkt);
      check("err_cnt", 32'(err_cnt), m_err);
    end
  end

  function automatic logic [31:0] hit(input int ch);
    return 32'(hits[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic step();
    @(negedge clk);
    if (rnd_empty) mac.empty = 2'($urandom_range(0, 3));
    if (rnd_match) match = 4'($urandom);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; step(); step(); n_rst = 1'b1;
  endtask

  task automatic cfg(input logic [11:0] w, input logic [5:0] t);
    weights = w; threshold = t; update_done = 1'b1; step();
    update_done = 1'b0; weights = 12'($urandom); threshold = 6'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_ph != P_IDLE && n < 40) begin step(); n++; end
    if (m_ph != P_IDLE) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: phase %0d, required %0d", m_ph, P_IDLE);
    end
  endtask

  task automatic send_pkt(input int len, input logic [3:0] m, input int err_at);
    wait_idle();
    for (int i = 0; i < len; i++) begin
      mac.sop = (i == 0); mac.valid = 1'b1; mac.eop = (i == len - 1);
      mac.error = (i == err_at) ? 6'($urandom_range(1, 63)) : 6'd0;
      if (!rnd_match) match = m;
      if (i == len - 1) eop_cyc = cyc + 1;
      step();
    end
    mac.sop = 1'b0; mac.valid = 1'b0; mac.eop = 1'b0; mac.error = 6'd0;
  endtask

  initial begin
    int inc_base, len, err_at;
    mac.sop = 1'b0; mac.eop = 1'b0; mac.valid = 1'b0; mac.error = '0; mac.empty = '0;
    step(); step();
    chk_en = 1;
    check("rst_ready", {31'd0, mac.ready}, 0);
    check("rst_clear", {31'd0, clear}, 0);
    check("rst_pkt", 32'(pkt_cnt), 0);
    n_rst = 1'b1;

    // weights url=4 mac=2 ip=2 port=1, threshold 4
    cfg({3'd4, 3'd2, 3'd2, 3'd1}, 6'd4);
    inc_base = inc_cnt;
    send_pkt(4, 4'b0011, -1);
    repeat (COMP_LAT + 3) step();
    check("p1_hits0", hit(0), 1);
    check("p1_hits1", hit(1), 1);
    check("p1_hits3", hit(3), 0);
    check("p1_pkt", 32'(pkt_cnt), 1);
    check("p1_no_inc", inc_cnt - inc_base, 0);

    inc_base = inc_cnt;
    send_pkt(3, 4'b1000, -1);
    repeat (COMP_LAT + 3) step();
    check("p2_inc_count", inc_cnt - inc_base, 1);
    check("p2_inc_delay", inc_cyc - eop_cyc, COMP_LAT + 1);
    check("p2_hits3", hit(3), 1);

    // errored packet: error two cycles before eop
    wait_idle();
    mac.sop = 1'b1; mac.valid = 1'b1; step();
    mac.sop = 1'b0; step();
    mac.error = 6'h01; step();
    check("err_ready", {31'd0, mac.ready}, 1);
    check("err_clear", {31'd0, clear}, 0);
    mac.error = 6'h00; step();
    check("err_hold_ready", {31'd0, mac.ready}, 1);
    mac.eop = 1'b1; step();
    mac.eop = 1'b0; mac.valid = 1'b0;
    check("err_idle_clear", {31'd0, clear}, 1);
    check("err_pkt", 32'(pkt_cnt), 2);
    check("err_cnt", 32'(err_cnt), ERR_ONE);

    mac.empty = 2'd3; step();
    check("empty3_ready", {31'd0, mac.ready}, 0);
    mac.empty = 2'd2; step();
    check("empty2_ready", {31'd0, mac.ready}, 1);
    mac.empty = 2'd0;

    do_reset();
    cfg({3'd4, 3'd2, 3'd2, 3'd1}, 6'd4);
    for (int p = 1; p <= 17; p++) begin
      send_pkt(3, 4'b0001, -1);
      repeat (COMP_LAT + 3) step();
      if (p >= 15) check("sat_hits0", hit(0), 15);
    end
    check("sat_pkt", 32'(pkt_cnt), 15);

    send_pkt(3, 4'b1111, -1);
    step();
    n_rst = 1'b0; step(); n_rst = 1'b1;
    check("mid_rst_ready", {31'd0, mac.ready}, 0);
    check("mid_rst_clear", {31'd0, clear}, 0);
    check("mid_rst_inc", {31'd0, inc_addr}, 0);
    check("mid_rst_hits", 32'(hits), 0);
    check("mid_rst_pkt", 32'(pkt_cnt), 0);
    repeat (3) begin step(); check("load_ready", {31'd0, mac.ready}, 0); end
    cfg({3'd1, 3'd1, 3'd1, 3'd1}, 6'd2);
    check("after_cfg_ready", {31'd0, mac.ready}, 1);

    rnd_empty = 1; rnd_match = 1;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) step();
      cfg(12'($urandom), 6'($urandom_range(0, 20)));
      for (int p = 0; p < 8; p++) begin
        repeat ($urandom_range(0, 3)) begin mac.sop = 1'($urandom); step(); end
        mac.sop = 1'b0;
        len = $urandom_range(2, 6);
        err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
        send_pkt(len, 4'd0, err_at);
      end
      repeat (COMP_LAT + 4) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run not finished, limit %0d time units", 500000);
    $fatal(1, "watchdog expired");
  end
endmodule
